// File: rtl/metro_code_entry_if.sv
// Keypad and downstream-gate signal bundle for metro_code_entry.
// master = the code-entry block, slave = keypad/downstream side.
interface metro_code_entry_if;
    logic       key_strobe;
    logic [3:0] key_val;
    logic [1:0] fsm_state;
    logic       validate_code;
    logic [3:0] access_code;
    logic       code_err;
    logic       timeout_p;
    logic [1:0] entry_state;
    logic       lockout;

    modport master (
        input  key_strobe, key_val, fsm_state,
        output validate_code, access_code, code_err, timeout_p, entry_state, lockout
    );

    modport slave (
        output key_strobe, key_val, fsm_state,
        input  validate_code, access_code, code_err, timeout_p, entry_state, lockout
    );
endinterface

// File: rtl/metro_code_entry.sv
// Keypad code-entry front end: collects up to two decimal digits and issues a 4-bit code to the
// gate FSM when it is idle. Optional failure lockout is built when CODE_ENTRY_LOCKOUT_EN is defined.
module metro_code_entry #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCK_CYC    = 32
) (
    input logic               clk,
    input logic               reset_n,
    metro_code_entry_if.master bus
);
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_COLLECT = 2'b01;
    localparam logic [1:0] ST_WAIT_DS = 2'b10;
    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);

    logic [1:0] state_q, state_d;
    logic [6:0] acc_q, acc_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       tmo_q, tmo_d;
    logic       locked;
    logic       is_digit, is_clear, is_enter;
    logic [6:0] acc_mac;

    assign is_digit = bus.key_strobe && (bus.key_val <= 4'd9);
    assign is_clear = bus.key_strobe && (bus.key_val == KEY_CLEAR);
    assign is_enter = bus.key_strobe && (bus.key_val == KEY_ENTER);
    // acc*10 + d; only used while acc holds a single digit, so 7 bits never overflow
    assign acc_mac  = (acc_q << 3) + (acc_q << 1) + {3'b000, bus.key_val};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        code_d  = code_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        if (locked) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_digit) begin
                        acc_d   = {3'b000, bus.key_val};
                        cnt_d   = 2'd1;
                        timer_d = '0;
                        state_d = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (bus.key_strobe) begin
                        timer_d = '0;
                        if (is_digit) begin
                            if (cnt_q < 2'd2) begin
                                acc_d = acc_mac;
                                cnt_d = cnt_q + 2'd1;
                            end
                        end else if (is_clear) begin
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else if (is_enter) begin
                            if (acc_q <= 7'd15) begin
                                pend_d  = acc_q[3:0];
                                state_d = ST_WAIT_DS;
                            end else begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end
                            acc_d = '0;
                            cnt_d = '0;
                        end
                    end else if (timer_q == TMO_LAST) begin
                        tmo_d   = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                ST_WAIT_DS: begin
                    // CLEAR takes priority over a same-cycle downstream IDLE
                    if (is_clear) begin
                        state_d = ST_IDLE;
                    end else if (bus.fsm_state == 2'b00) begin
                        valid_d = 1'b1;
                        code_d  = pend_q;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef CODE_ENTRY_LOCKOUT_EN
    logic [7:0] fail_q;
    logic [7:0] lock_tmr_q;
    logic       lock_q;

    // Lockout rises together with the code_err pulse that reaches MAX_FAIL
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_q     <= '0;
            lock_tmr_q <= '0;
            lock_q     <= 1'b0;
        end else if (lock_q) begin
            if (lock_tmr_q == 8'(LOCK_CYC - 1)) begin
                lock_q     <= 1'b0;
                lock_tmr_q <= '0;
                fail_q     <= '0;
            end else begin
                lock_tmr_q <= lock_tmr_q + 8'd1;
            end
        end else if (valid_d) begin
            fail_q <= '0;
        end else if (err_d) begin
            if (fail_q + 8'd1 == 8'(MAX_FAIL)) begin
                lock_q     <= 1'b1;
                lock_tmr_q <= '0;
            end
            fail_q <= fail_q + 8'd1;
        end
    end

    assign locked = lock_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{8'(MAX_FAIL), 8'(LOCK_CYC)};
    assign locked     = 1'b0;
`endif

    assign bus.validate_code = valid_q;
    assign bus.access_code   = code_q;
    assign bus.code_err      = err_q;
    assign bus.timeout_p     = tmo_q;
    assign bus.entry_state   = state_q;
    assign bus.lockout       = locked;
endmodule

// File: tb/tb_metro_code_entry.sv
// Directed self-checking bench for metro_code_entry; lockout steps run only when
// CODE_ENTRY_LOCKOUT_EN is defined.
module tb_metro_code_entry;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    metro_code_entry_if bus_if ();

    metro_code_entry #(
        .TIMEOUT_CYC(16),
        .MAX_FAIL   (3),
        .LOCK_CYC   (32)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] v);
        bus_if.key_strobe = 1'b1;
        bus_if.key_val    = v;
        step();
        bus_if.key_strobe = 1'b0;
        bus_if.key_val    = 4'h0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total                = 0;
        bad                  = 0;
        reset_n              = 1'b0;
        bus_if.key_strobe    = 1'b0;
        bus_if.key_val       = 4'h0;
        bus_if.fsm_state     = 2'b00;
        step();
        step();
        check("rst_valid", 8'(bus_if.validate_code), 8'h0);
        check("rst_code", 8'(bus_if.access_code), 8'h0);
        check("rst_err", 8'(bus_if.code_err), 8'h0);
        check("rst_tmo", 8'(bus_if.timeout_p), 8'h0);
        check("rst_state", 8'(bus_if.entry_state), 8'h0);
        check("rst_lock", 8'(bus_if.lockout), 8'h0);
        reset_n = 1'b1;
        step();

        // 1,2,ENTER with downstream idle -> 12 issued two cycles after ENTER
        key(4'd1);
        check("collect_state", 8'(bus_if.entry_state), 8'h1);
        key(4'd2);
        key(4'hB);
        check("wait_state", 8'(bus_if.entry_state), 8'h2);
        check("wait_no_valid", 8'(bus_if.validate_code), 8'h0);
        step();
        check("issue12_valid", 8'(bus_if.validate_code), 8'h1);
        check("issue12_code", 8'(bus_if.access_code), 8'd12);
        check("issue12_idle", 8'(bus_if.entry_state), 8'h0);
        step();
        check("issue12_pulse", 8'(bus_if.validate_code), 8'h0);
        check("issue12_hold", 8'(bus_if.access_code), 8'd12);

        // 2,0,ENTER -> range error, code kept
        key(4'd2);
        key(4'd0);
        key(4'hB);
        check("err20_pulse", 8'(bus_if.code_err), 8'h1);
        check("err20_valid", 8'(bus_if.validate_code), 8'h0);
        check("err20_state", 8'(bus_if.entry_state), 8'h0);
        step();
        check("err20_one", 8'(bus_if.code_err), 8'h0);
        check("err20_valid2", 8'(bus_if.validate_code), 8'h0);
        check("err20_code", 8'(bus_if.access_code), 8'd12);

        // 5,ENTER with downstream busy for 6 cycles
        bus_if.fsm_state = 2'b10;
        key(4'd5);
        key(4'hB);
        for (int i = 0; i < 6; i++) begin
            check("busy_no_valid", 8'(bus_if.validate_code), 8'h0);
            check("busy_wait", 8'(bus_if.entry_state), 8'h2);
            step();
        end
        bus_if.fsm_state = 2'b00;
        step();
        check("issue5_valid", 8'(bus_if.validate_code), 8'h1);
        check("issue5_code", 8'(bus_if.access_code), 8'd5);
        step();

        // Leading zero: 0,7 -> 7
        key(4'd0);
        key(4'd7);
        key(4'hB);
        step();
        check("issue7_valid", 8'(bus_if.validate_code), 8'h1);
        check("issue7_code", 8'(bus_if.access_code), 8'd7);
        step();

        // CLEAR in WAIT_DS alongside downstream idle wins
        bus_if.fsm_state = 2'b10;
        key(4'd3);
        key(4'hB);
        bus_if.fsm_state = 2'b00;
        key(4'hA);
        check("clrwin_valid", 8'(bus_if.validate_code), 8'h0);
        check("clrwin_state", 8'(bus_if.entry_state), 8'h0);
        check("clrwin_code", 8'(bus_if.access_code), 8'd7);
        step();
        check("clrwin_valid2", 8'(bus_if.validate_code), 8'h0);

        // 9 then silence -> timeout pulse after 16 idle cycles
        key(4'd9);
        repeat (15) step();
        check("tmo_early", 8'(bus_if.timeout_p), 8'h0);
        check("tmo_early_st", 8'(bus_if.entry_state), 8'h1);
        step();
        check("tmo_pulse", 8'(bus_if.timeout_p), 8'h1);
        check("tmo_state", 8'(bus_if.entry_state), 8'h0);
        step();
        check("tmo_one", 8'(bus_if.timeout_p), 8'h0);
        key(4'hB);
        check("tmo_enter_st", 8'(bus_if.entry_state), 8'h0);
        step();
        check("tmo_enter_v", 8'(bus_if.validate_code), 8'h0);
        check("tmo_enter_e", 8'(bus_if.code_err), 8'h0);

        // 1,3,7,ENTER -> third digit dropped, 13 issued
        key(4'd1);
        key(4'd3);
        key(4'd7);
        key(4'hB);
        step();
        check("issue13_valid", 8'(bus_if.validate_code), 8'h1);
        check("issue13_code", 8'(bus_if.access_code), 8'd13);
        step();

        // 4,CLEAR,6,ENTER -> 6 issued
        key(4'd4);
        key(4'hA);
        check("clr_idle", 8'(bus_if.entry_state), 8'h0);
        key(4'd6);
        key(4'hB);
        step();
        check("issue6_valid", 8'(bus_if.validate_code), 8'h1);
        check("issue6_code", 8'(bus_if.access_code), 8'd6);
        step();

        // Range boundary: 15 issues, 16 errors
        key(4'd1);
        key(4'd5);
        key(4'hB);
        step();
        check("issue15_code", 8'(bus_if.access_code), 8'd15);
        check("issue15_valid", 8'(bus_if.validate_code), 8'h1);
        step();
        key(4'd1);
        key(4'd6);
        key(4'hB);
        check("err16_pulse", 8'(bus_if.code_err), 8'h1);
        step();
        check("err16_valid", 8'(bus_if.validate_code), 8'h0);
        check("err16_code", 8'(bus_if.access_code), 8'd15);

        // Reset during WAIT_DS aborts silently
        bus_if.fsm_state = 2'b01;
        key(4'd8);
        key(4'hB);
        check("rst_wait_pre", 8'(bus_if.entry_state), 8'h2);
        reset_n = 1'b0;
        #1;
        check("rstw_state", 8'(bus_if.entry_state), 8'h0);
        check("rstw_code", 8'(bus_if.access_code), 8'h0);
        check("rstw_valid", 8'(bus_if.validate_code), 8'h0);
        check("rstw_err", 8'(bus_if.code_err), 8'h0);
        check("rstw_tmo", 8'(bus_if.timeout_p), 8'h0);
        step();
        reset_n          = 1'b1;
        bus_if.fsm_state = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstw_no_issue", 8'(bus_if.validate_code), 8'h0);
        end
        check("rstw_code_after", 8'(bus_if.access_code), 8'h0);

`ifdef CODE_ENTRY_LOCKOUT_EN
        // Three 99 entries -> 32-cycle lockout, keys ignored meanwhile
        for (int n = 0; n < 3; n++) begin
            key(4'd9);
            key(4'd9);
            key(4'hB);
        end
        check("lock_err", 8'(bus_if.code_err), 8'h1);
        check("lock_on", 8'(bus_if.lockout), 8'h1);
        key(4'd4);
        check("lock_ignore", 8'(bus_if.entry_state), 8'h0);
        key(4'hB);
        check("lock_no_valid", 8'(bus_if.validate_code), 8'h0);
        repeat (29) step();
        check("lock_last", 8'(bus_if.lockout), 8'h1);
        step();
        check("lock_release", 8'(bus_if.lockout), 8'h0);
        key(4'd4);
        key(4'hB);
        step();
        check("postlock_valid", 8'(bus_if.validate_code), 8'h1);
        check("postlock_code", 8'(bus_if.access_code), 8'd4);
`else
        key(4'd9);
        key(4'd9);
        key(4'hB);
        check("nolock_err", 8'(bus_if.code_err), 8'h1);
        check("nolock_lock", 8'(bus_if.lockout), 8'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
